// File: rtl/arbitro_botones_if.sv
// -----------------------------------------------------------------------------
// arbitro_botones_if
// Event handshake between the push-button arbiter and the core.
//   evento_valido_o : an event is being offered (arbiter -> core)
//   evento_codigo_o : offered button, U=0 D=1 L=2 R=3 (arbiter -> core)
//   evento_ack_i    : core consumes the offered event (core -> arbiter)
// The signal names keep the arbiter-side direction suffixes so they read the
// same at both ends of the link.
// Modports: master = arbiter (event source), slave = core (event sink).
// -----------------------------------------------------------------------------
interface arbitro_botones_if;
  logic       evento_valido_o;
  logic [1:0] evento_codigo_o;
  logic       evento_ack_i;

  modport master (
    output evento_valido_o,
    output evento_codigo_o,
    input  evento_ack_i
  );

  modport slave (
    input  evento_valido_o,
    input  evento_codigo_o,
    output evento_ack_i
  );
endinterface

// File: rtl/arbitro_botones.sv
// -----------------------------------------------------------------------------
// arbitro_botones
// Front end for the four board push-buttons (U, D, L, R, active-low raw).
// Each button is synchronized (2 flops) and debounced on its own. A debounced
// press (stable 1->0) latches a pending bit. A round-robin arbiter then offers
// the pending events one at a time to the core over a valid/ack handshake.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_n_i          synchronous reset, active-low
//   botonU/D/L/R_pi  raw buttons, active-low, asynchronous
//   evt              event handshake (master side: valido, codigo, ack)
//   pendientes_o     pending bits, [0]=U [1]=D [2]=L [3]=R
//   perdidos_o       saturating count of presses lost on an already-set bit
// -----------------------------------------------------------------------------
module arbitro_botones #(
  parameter int CUENTA_DB = 15
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               botonU_pi,
  input  logic               botonD_pi,
  input  logic               botonL_pi,
  input  logic               botonR_pi,
  arbitro_botones_if.master  evt,
  output logic [3:0]         pendientes_o,
  output logic [7:0]         perdidos_o
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_OFRECER = 1'b1
  } estado_t;

  localparam logic [CUENTA_DB-1:0] CNT_MAX = '1;

  // Raw inputs packed in the same bit order as the event codes.
  logic [3:0] w_raw;
  assign w_raw = {botonR_pi, botonL_pi, botonD_pi, botonU_pi};

  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic [3:0]           r_estable;
  logic [3:0]           r_estable_d;
  logic [CUENTA_DB-1:0] r_cnt [4];

  logic [3:0] r_pend;
  logic [7:0] r_perdidos;
  logic [1:0] r_codigo;
  logic [1:0] r_ptr;
  estado_t    r_estado;
  estado_t    w_estado_next;

  logic [3:0] w_press;
  logic [3:0] w_clr;
  logic [3:0] w_perdido;
  logic [2:0] w_n_perd;
  logic [8:0] w_perd_sum;
  logic [7:0] w_perd_next;
  logic [1:0] w_sel;
  logic [1:0] w_idx;
  logic       w_hallado;
  logic       w_ack;

  // ---------------------------------------------------------------------------
  // Synchronizer + debounce
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the 2-flop
  // synchronizer into a single stage.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync1     <= 4'hF;
      r_sync2     <= 4'hF;
      r_estable   <= 4'hF;
      r_estable_d <= 4'hF;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1     <= w_raw;
      r_sync2     <= r_sync1;
      r_estable_d <= r_estable;
      for (int i = 0; i < 4; i++) begin
        // Any cycle where the input agrees with the stable state restarts
        // the count, so only an uninterrupted run of 2**CUENTA_DB cycles
        // changes the stable state.
        if (r_sync2[i] == r_estable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_estable[i] <= r_sync2[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle pulse on a debounced press only; releases are ignored.
  assign w_press = r_estable_d & ~r_estable;
  assign w_ack   = evt.evento_ack_i;

  // ---------------------------------------------------------------------------
  // Pending bits and lost-press counter
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    w_clr = '0;
    if (r_estado == ST_OFRECER && w_ack) w_clr[r_codigo] = 1'b1;
  end

  // A press on a bit being cleared the same cycle re-arms it and is not lost.
  assign w_perdido = w_press & r_pend & ~w_clr;

  always_comb begin
    w_n_perd    = {2'b00, w_perdido[0]} + {2'b00, w_perdido[1]}
                + {2'b00, w_perdido[2]} + {2'b00, w_perdido[3]};
    w_perd_sum  = {1'b0, r_perdidos} + {6'b000000, w_n_perd};
    w_perd_next = w_perd_sum[8] ? 8'hFF : w_perd_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first set bit at ptr, ptr+1, ... (mod 4)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel     = r_ptr;
    w_idx     = '0;
    w_hallado = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_hallado && r_pend[w_idx]) begin
        w_sel     = w_idx;
        w_hallado = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_estado <= ST_IDLE;
    else          r_estado <= w_estado_next;
  end

  // Arbiter FSM: next state
  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      ST_IDLE:    if (w_hallado) w_estado_next = ST_OFRECER;
      ST_OFRECER: if (w_ack)     w_estado_next = ST_IDLE;
      default:                   w_estado_next = ST_IDLE;
    endcase
  end

  // Arbiter FSM: outputs (valido follows the state register directly)
  always_comb begin
    evt.evento_valido_o = (r_estado == ST_OFRECER);
    evt.evento_codigo_o = r_codigo;
  end

  // ---------------------------------------------------------------------------
  // Arbiter datapath: offered code, rotation pointer, pending/lost registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_codigo   <= '0;
      r_ptr      <= '0;
      r_pend     <= '0;
      r_perdidos <= '0;
    end else begin
      if (r_estado == ST_IDLE && w_hallado) r_codigo <= w_sel;
      // Grant rotates past the code just consumed (2-bit wrap).
      if (r_estado == ST_OFRECER && w_ack)  r_ptr    <= r_codigo + 2'd1;
      r_pend     <= (r_pend & ~w_clr) | w_press;
      r_perdidos <= w_perd_next;
    end
  end

  assign pendientes_o = r_pend;
  assign perdidos_o   = r_perdidos;

endmodule

// File: tb/tb_arbitro_botones.sv
// -----------------------------------------------------------------------------
// tb_arbitro_botones
// Self-checking bench for arbitro_botones with CUENTA_DB=3 (8-cycle debounce).
// Directed steps cover reset, press latency, glitch rejection, round-robin
// order, lost-press saturation, set/clear collision and reset mid-handshake.
// A randomized phase compares against a set-based model of pending events.
// -----------------------------------------------------------------------------
module tb_arbitro_botones;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       b_u, b_d, b_l, b_r;
  logic [3:0] pend;
  logic [7:0] perd;

  arbitro_botones_if u_if ();

  arbitro_botones #(.CUENTA_DB(3)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .botonU_pi    (b_u),
    .botonD_pi    (b_d),
    .botonL_pi    (b_l),
    .botonR_pi    (b_r),
    .evt          (u_if),
    .pendientes_o (pend),
    .perdidos_o   (perd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bit = 1 means that button is pressed (raw pin low).
  task automatic set_btn(input logic [3:0] m);
    {b_r, b_l, b_d, b_u} = ~m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    u_if.evento_ack_i = 1'b0;
    set_btn(4'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Hold long enough to debounce the press, then long enough to debounce
  // the release, leaving every button stably released.
  task automatic press_release(input logic [3:0] m);
    set_btn(m);
    repeat (14) tick();
    set_btn(4'h0);
    repeat (14) tick();
  endtask

  task automatic ack_once();
    u_if.evento_ack_i = 1'b1;
    tick();
    u_if.evento_ack_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (u_if.evento_valido_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Reference rule: first pending button searching ptr, ptr+1, ... mod 4.
  function automatic int pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < 4; k++)
      if (p[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  logic [3:0] m_pend;
  int         m_ptr, m_lost, m_offer, n_srv;
  logic [3:0] mask;
  bit         seen;

  initial begin
    // ---------------- reset, idle, held ack ignored ----------------
    do_reset();
    u_if.evento_ack_i = 1'b1;
    repeat (20) tick();
    u_if.evento_ack_i = 1'b0;
    check("rst_valido", 32'(u_if.evento_valido_o), 32'd0);
    check("rst_codigo", 32'(u_if.evento_codigo_o), 32'd0);
    check("rst_pend",   32'(pend), 32'd0);
    check("rst_perd",   32'(perd), 32'd0);

    // ---------------- D held 12 cycles: latency ----------------
    set_btn(4'b0010);
    repeat (10) tick();
    check("d_pend_early", 32'(pend), 32'd0);
    tick();
    check("d_pend_at11", 32'(pend), 32'b0010);
    check("d_valid_at11", 32'(u_if.evento_valido_o), 32'd0);
    tick();
    check("d_valid_at12", 32'(u_if.evento_valido_o), 32'd1);
    check("d_code", 32'(u_if.evento_codigo_o), 32'd1);
    set_btn(4'h0);
    repeat (3) tick();
    ack_once();
    check("d_ack_valid", 32'(u_if.evento_valido_o), 32'd0);
    check("d_ack_pend",  32'(pend), 32'd0);
    check("d_ack_perd",  32'(perd), 32'd0);
    repeat (14) tick();
    check("d_no_release_event", 32'(pend), 32'd0);

    // ---------------- U glitching faster than the debounce ----------------
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      b_u = ~b_u;
      repeat (4) begin
        tick();
        if (pend !== 4'h0 || u_if.evento_valido_o !== 1'b0) seen = 1'b1;
      end
    end
    b_u = 1'b1;
    repeat (12) begin
      tick();
      if (pend !== 4'h0 || u_if.evento_valido_o !== 1'b0) seen = 1'b1;
    end
    check("glitch_no_event", 32'(seen), 32'd0);

    // ---------------- all four at once: round-robin 0,1,2,3 twice ----------------
    do_reset();
    for (int r = 0; r < 2; r++) begin
      press_release(4'hF);
      check("rr_pend", 32'(pend), 32'hF);
      for (int c = 0; c < 4; c++) begin
        wait_valid("rr_wait");
        check($sformatf("rr_code_r%0d_%0d", r, c), 32'(u_if.evento_codigo_o), 32'(c));
        repeat (3) tick();
        ack_once();
      end
      repeat (4) tick();
      check("rr_empty_valid", 32'(u_if.evento_valido_o), 32'd0);
      check("rr_perd", 32'(perd), 32'd0);
    end

    // ---------------- lost presses on L, then saturation ----------------
    do_reset();
    press_release(4'b0100);
    check("l_code", 32'(u_if.evento_codigo_o), 32'd2);
    press_release(4'b0100);
    check("l_perd1", 32'(perd), 32'd1);
    check("l_pend",  32'(pend), 32'b0100);
    ack_once();
    repeat (5) tick();
    check("l_single_event", 32'(u_if.evento_valido_o), 32'd0);
    check("l_pend_clear",   32'(pend), 32'd0);
    m_lost = 1;
    for (int i = 0; i < 300; i++) begin
      press_release(4'b0100);
      if (i > 0 && m_lost < 255) m_lost++;
      if (i % 50 == 49) check("l_perd_mid", 32'(perd), 32'(m_lost));
    end
    check("l_perd_sat", 32'(perd), 32'd255);

    // ---------------- set and clear on the same edge: set wins ----------------
    do_reset();
    press_release(4'b0001);
    check("sc_code", 32'(u_if.evento_codigo_o), 32'd0);
    set_btn(4'b0001);
    repeat (10) tick();
    u_if.evento_ack_i = 1'b1;
    tick();
    u_if.evento_ack_i = 1'b0;
    check("sc_pend",  32'(pend), 32'b0001);
    check("sc_perd",  32'(perd), 32'd0);
    check("sc_valid_drop", 32'(u_if.evento_valido_o), 32'd0);
    tick();
    check("sc_reoffer", 32'(u_if.evento_valido_o), 32'd1);
    check("sc_recode",  32'(u_if.evento_codigo_o), 32'd0);
    set_btn(4'h0);
    repeat (14) tick();

    // ---------------- reset mid-handshake ----------------
    do_reset();
    press_release(4'b1100);
    check("mr_valid", 32'(u_if.evento_valido_o), 32'd1);
    check("mr_code",  32'(u_if.evento_codigo_o), 32'd2);
    check("mr_pend",  32'(pend), 32'b1100);
    rst_n = 1'b0;
    tick();
    check("mr_rst_valid", 32'(u_if.evento_valido_o), 32'd0);
    check("mr_rst_pend",  32'(pend), 32'd0);
    check("mr_rst_code",  32'(u_if.evento_codigo_o), 32'd0);
    rst_n = 1'b1;
    repeat (30) tick();
    check("mr_no_event", 32'(u_if.evento_valido_o), 32'd0);
    press_release(4'hF);
    check("mr_ptr0", 32'(u_if.evento_codigo_o), 32'd0);

    // ---------------- randomized presses and acks vs set model ----------------
    do_reset();
    m_pend  = 4'h0;
    m_ptr   = 0;
    m_lost  = 0;
    m_offer = -1;
    for (int it = 0; it < 25; it++) begin
      mask = 4'($urandom_range(0, 15));
      press_release(mask);
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (m_pend[i]) begin
            if (m_lost < 255) m_lost++;
          end else begin
            m_pend[i] = 1'b1;
          end
        end
      end
      if (m_offer < 0) m_offer = pick(m_pend, m_ptr);
      check("rnd_pend",  32'(pend), 32'(m_pend));
      check("rnd_perd",  32'(perd), 32'(m_lost));
      check("rnd_valid", 32'(u_if.evento_valido_o), 32'(m_offer >= 0));
      if (m_offer >= 0) check("rnd_code", 32'(u_if.evento_codigo_o), 32'(m_offer));
      n_srv = $urandom_range(0, $countones(m_pend));
      for (int s = 0; s < n_srv; s++) begin
        repeat ($urandom_range(0, 3)) tick();
        check("rnd_srv_code", 32'(u_if.evento_codigo_o), 32'(m_offer));
        ack_once();
        m_pend[m_offer] = 1'b0;
        m_ptr   = (m_offer + 1) % 4;
        m_offer = pick(m_pend, m_ptr);
        tick();
        tick();
        check("rnd_srv_pend",  32'(pend), 32'(m_pend));
        check("rnd_srv_valid", 32'(u_if.evento_valido_o), 32'(m_offer >= 0));
        if (m_offer >= 0) check("rnd_srv_next", 32'(u_if.evento_codigo_o), 32'(m_offer));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
